// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO: buffers {PC, instruction} pairs from fetch and hands them to decode.
// Optional occupancy/stall statistics are enabled with `define IF_ID_QUEUE_STATS_EN.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr,
  input  logic             flush,
  output logic [AW:0]      count
`ifdef IF_ID_QUEUE_STATS_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flushed_entries
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem_pc    [DEPTH];
  logic [WIDTH-1:0] r_mem_instr [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Handshake status derives only from the registered count, so in_ready has no path from out_ready.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full & ~flush;
  assign w_pop   = out_ready & ~w_empty & ~flush;

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign count     = r_count;

  // Empty head reads as all-zero, which decode treats as a bubble.
  assign out_pc    = w_empty ? '0 : r_mem_pc[r_rd_ptr];
  assign out_instr = w_empty ? '0 : r_mem_instr[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= in_pc;
      r_mem_instr[r_wr_ptr] <= in_instr;
    end
  end

`ifdef IF_ID_QUEUE_STATS_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flushed_entries;
  logic [16:0] w_flush_sum;

  assign w_flush_sum     = 17'(r_flushed_entries) + 17'(r_count);
  assign stall_cycles    = r_stall_cycles;
  assign flushed_entries = r_flushed_entries;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles    <= '0;
      r_flushed_entries <= '0;
    end else begin
      if (in_valid && w_full && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (flush) begin
        r_flushed_entries <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a queue-based model checked every cycle plus literal spot checks.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int AW    = 1;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_pc = '0;
  logic [WIDTH-1:0] in_instr = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_instr;
  logic             flush = 1'b0;
  logic [AW:0]      count;
`ifdef IF_ID_QUEUE_STATS_EN
  logic [15:0]      stall_cycles;
  logic [15:0]      flushed_entries;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  if_id_queue #(.DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .flush(flush), .count(count)
`ifdef IF_ID_QUEUE_STATS_EN
    , .stall_cycles(stall_cycles), .flushed_entries(flushed_entries)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an ordered list of {pc, instr} entries.
  logic [63:0] mq[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else if (in_valid && mq.size() != DEPTH) begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      mq.push_back({in_pc, in_instr});
    end else if (mq.size() != 0 && out_ready) begin
      void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("count", 64'(count), 64'(mq.size()));
      check("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("out_pc", 64'(out_pc), (mq.size() != 0) ? 64'(mq[0][63:32]) : 64'd0);
      check("out_instr", 64'(out_instr), (mq.size() != 0) ? 64'(mq[0][31:0]) : 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = 32'hE000_0000 | pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    step();
    step();
    rst = 1'b1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    step();

    // Single push becomes visible one cycle later.
    in_valid = 1'b1; in_pc = 32'd4; in_instr = 32'hE3A01001; out_ready = 1'b0;
    step();
    idle();
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_pc", 64'(out_pc), 64'd4);
    check("t1_out_instr", 64'(out_instr), 64'hE3A01001);
    check("t1_count", 64'(count), 64'd1);

    // Fill, then a push while full is ignored.
    drive(1'b1, 32'd8, 1'b0, 1'b0);
    step();
    check("t2_count", 64'(count), 64'd2);
    check("t2_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'd12, 1'b0, 1'b0);
    step();
    check("t2_hold_pc", 64'(out_pc), 64'd4);
    check("t2_hold_count", 64'(count), 64'd2);

    // Drain to empty, then stream with simultaneous push/pop.
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    step();
    step();
    check("t3_empty", 64'(out_valid), 64'd0);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 32'(4 * k), 1'b1, 1'b0);
      step();
      check("t3_stream_pc", 64'(out_pc), 64'(4 * k));
      check("t3_stream_count", 64'(count), 64'd1);
    end

    // Fill to two, then flush with a coincident push and pop.
    drive(1'b1, 32'd28, 1'b0, 1'b0);
    step();
    check("t4_pre_count", 64'(count), 64'd2);
    drive(1'b1, 32'd20, 1'b1, 1'b1);
    step();
    check("t4_count", 64'(count), 64'd0);
    check("t4_out_valid", 64'(out_valid), 64'd0);
    check("t4_out_instr", 64'(out_instr), 64'd0);
    check("t4_in_ready", 64'(in_ready), 64'd1);
    idle();
    step();
    check("t4_no_pc20", 64'(out_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(100 + 4 * k), 1'b1, 1'b1);
      step();
      check("t4_held_flush", 64'(count), 64'd0);
    end

    // Mixed traffic pattern checked by the model.
    for (int i = 0; i < 40; i++) begin
      drive((i % 3) != 0, 32'(200 + 4 * i), (i % 4) < 2, i == 25);
      step();
    end

    // Asynchronous reset between edges.
    drive(1'b1, 32'd300, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'd304, 1'b0, 1'b0);
    step();
    idle();
    check("t5_pre_count", 64'(count), 64'd2);
    #1;
    rst = 1'b0;
    #1;
    check("t5_count", 64'(count), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    check("t5_out_pc", 64'(out_pc), 64'd0);
    step();
    rst = 1'b1;
    step();

`ifdef IF_ID_QUEUE_STATS_EN
    check("t6_stall_rst", 64'(stall_cycles), 64'd0);
    drive(1'b1, 32'd400, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'd404, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'd408, 1'b0, 1'b0);
      step();
    end
    check("t6_stall", 64'(stall_cycles), 64'd5);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    step();
    idle();
    check("t6_flushed", 64'(flushed_entries), 64'd2);
    step();
`endif

    idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
